wb_stage: RTL and testbench

//  Load/store + writeback end of the pipeline; drives regfile_{waddr,we,wdata}_wb into id_stage.

---
 rtl/wb_stage.sv | 188 ++++++++++++++++++
 tb/tb_wb_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: EX/WB register, data-memory req/gnt/rvalid handshake, load align/extend and writeback select.
// Optional WB_MISALIGN_CHK_EN: reject misaligned H/W accesses (misalign_err_o) instead of forcing alignment.
module wb_stage #(
    parameter int TIMEOUT            = 16,
    parameter int PC_INCR            = 4,
    parameter int WB_WR_MUX_OP_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  logic [31:0]                   pc_i,
    input  logic [31:0]                   alu_result_i,
    input  logic [31:0]                   rs2_rdata_i,
    input  logic [4:0]                    regfile_waddr_i,
    input  logic                          regfile_we_i,
    input  logic [WB_WR_MUX_OP_WIDTH-1:0] regfile_wr_mux_i,
    input  logic                          mem_req_i,
    input  logic                          mem_we_i,
    input  logic [2:0]                    mem_be_i,
    output logic                          stall_wb_o,
    output logic                          data_req_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    input  logic [31:0]                   data_rdata_i,
    output logic [31:0]                   data_addr_o,
    output logic                          data_we_o,
    output logic [3:0]                    data_be_o,
    output logic [31:0]                   data_wdata_o,
    output logic [4:0]                    regfile_waddr_wb_o,
    output logic                          regfile_we_wb_o,
    output logic [31:0]                   regfile_wdata_wb_o,
    output logic                          bus_err_o,
    output logic                          misalign_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WB_WR_MUX_OP_WIDTH-1:0] WB_WR_MUX_MEM    = 1;
    localparam logic [WB_WR_MUX_OP_WIDTH-1:0] WB_WR_MUX_PCINCR = 2;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic                          q_valid, q_we, q_mem_req, q_mem_we;
    logic [31:0]                   q_pc, q_alu, q_rs2;
    logic [4:0]                    q_waddr;
    logic [WB_WR_MUX_OP_WIDTH-1:0] q_mux;
    logic [2:0]                    q_be;

    logic        q_mis, in_mis, mem_any, mem_op, issue;
    logic        in_xact, done, timeout, completes;
    logic [1:0]  off;
    logic [31:0] shifted, ld_data, wb_data, st_wd;
    logic [3:0]  st_be;

    function automatic logic be_legal(input logic [2:0] be);
        return (be == 3'b000) || (be == 3'b001) || (be == 3'b010) ||
               (be == 3'b100) || (be == 3'b101);
    endfunction

`ifdef WB_MISALIGN_CHK_EN
    function automatic logic misaligned(input logic [2:0] be, input logic [1:0] a);
        return ((be[1:0] == 2'b01) && a[0]) || ((be == 3'b010) && (a != 2'b00));
    endfunction
    assign q_mis  = misaligned(q_be, q_alu[1:0]);
    assign in_mis = misaligned(mem_be_i, alu_result_i[1:0]);
`else
    assign q_mis  = 1'b0;
    assign in_mis = 1'b0;
`endif

    assign mem_any = q_valid & q_mem_req;
    assign mem_op  = mem_any & be_legal(q_be) & ~q_mis;
    assign issue   = valid_i & mem_req_i & be_legal(mem_be_i) & ~in_mis;

    assign in_xact = (state != IDLE);
    assign done    = ((state == REQ) & data_gnt_i & q_mem_we) |
                     ((state == RESP) & data_rvalid_i);
    assign timeout = in_xact & ~done & (cnt == CW'(TIMEOUT - 1));

    assign stall_wb_o     = mem_op & ~done & ~timeout;
    assign bus_err_o      = timeout;
    assign misalign_err_o = mem_any & be_legal(q_be) & q_mis;

    // Byte offset into the word; without the misalign check H/W are forced onto their natural boundary.
    always_comb begin
        off = q_alu[1:0];
        if (q_be[1:0] == 2'b01)
            off = {q_alu[1], 1'b0};
        else if (q_be[1:0] == 2'b10)
            off = 2'b00;
    end

    assign shifted = data_rdata_i >> {off, 3'b000};

    always_comb begin
        case (q_be)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data = {24'b0, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        case (q_be[1:0])
            2'b00: begin
                st_be = 4'b0001 << off;
                st_wd = {4{q_rs2[7:0]}};
            end
            2'b01: begin
                st_be = 4'b0011 << off;
                st_wd = {2{q_rs2[15:0]}};
            end
            default: begin
                st_be = 4'b1111;
                st_wd = q_rs2;
            end
        endcase
    end

    always_comb begin
        wb_data = q_alu;
        case (q_mux)
            WB_WR_MUX_MEM:    wb_data = ld_data;
            WB_WR_MUX_PCINCR: wb_data = q_pc + 32'(PC_INCR);
            default:          ;
        endcase
    end

    // Memory ops write only on their done cycle; rejected memory ops never write.
    assign completes          = q_valid & (~q_mem_req | (mem_op & done));
    assign regfile_we_wb_o    = completes & q_we & (q_waddr != 5'd0);
    assign regfile_waddr_wb_o = q_waddr;
    assign regfile_wdata_wb_o = wb_data;

    assign data_addr_o  = data_req_o ? {q_alu[31:2], 2'b00} : 32'd0;
    assign data_we_o    = data_req_o & q_mem_we;
    assign data_be_o    = data_req_o ? st_be : 4'd0;
    assign data_wdata_o = data_req_o ? st_wd : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid    <= 1'b0;
            q_pc       <= '0;
            q_alu      <= '0;
            q_rs2      <= '0;
            q_waddr    <= '0;
            q_we       <= 1'b0;
            q_mux      <= '0;
            q_mem_req  <= 1'b0;
            q_mem_we   <= 1'b0;
            q_be       <= '0;
            state      <= IDLE;
            cnt        <= '0;
            data_req_o <= 1'b0;
        end else begin
            if (in_xact)
                cnt <= cnt + 1'b1;
            if (!stall_wb_o) begin
                q_valid   <= valid_i;
                q_pc      <= pc_i;
                q_alu     <= alu_result_i;
                q_rs2     <= rs2_rdata_i;
                q_waddr   <= regfile_waddr_i;
                q_we      <= regfile_we_i;
                q_mux     <= regfile_wr_mux_i;
                q_mem_req <= mem_req_i;
                q_mem_we  <= mem_we_i;
                q_be      <= mem_be_i;
                if (issue) begin
                    state      <= REQ;
                    data_req_o <= 1'b1;
                    cnt        <= '0;
                end else begin
                    state      <= IDLE;
                    data_req_o <= 1'b0;
                end
            end else if ((state == REQ) && data_gnt_i) begin
                state      <= RESP;
                data_req_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: transaction-level model sets per-cycle expectations, one negedge checker.
module tb_wb_stage;

    localparam int TIMEOUT = 16;
    localparam int PC_INCR = 4;
    localparam logic [1:0] M_ALU = 2'd0, M_MEM = 2'd1, M_PC = 2'd2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        valid_i = 0, regfile_we_i = 0, mem_req_i = 0, mem_we_i = 0;
    logic [31:0] pc_i = 0, alu_result_i = 0, rs2_rdata_i = 0, data_rdata_i = 0;
    logic [4:0]  regfile_waddr_i = 0;
    logic [1:0]  regfile_wr_mux_i = 0;
    logic [2:0]  mem_be_i = 0;
    logic        data_gnt_i = 0, data_rvalid_i = 0;
    logic        stall_wb_o, data_req_o, data_we_o, regfile_we_wb_o, bus_err_o, misalign_err_o;
    logic [31:0] data_addr_o, data_wdata_o, regfile_wdata_wb_o;
    logic [3:0]  data_be_o;
    logic [4:0]  regfile_waddr_wb_o;

    wb_stage #(.TIMEOUT(TIMEOUT), .PC_INCR(PC_INCR), .WB_WR_MUX_OP_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .alu_result_i(alu_result_i),
        .rs2_rdata_i(rs2_rdata_i), .regfile_waddr_i(regfile_waddr_i), .regfile_we_i(regfile_we_i),
        .regfile_wr_mux_i(regfile_wr_mux_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_be_i(mem_be_i), .stall_wb_o(stall_wb_o), .data_req_o(data_req_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .regfile_waddr_wb_o(regfile_waddr_wb_o),
        .regfile_we_wb_o(regfile_we_wb_o), .regfile_wdata_wb_o(regfile_wdata_wb_o),
        .bus_err_o(bus_err_o), .misalign_err_o(misalign_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, alu, rs2;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  mux;
        logic        mreq, mwe;
        logic [2:0]  be;
    } op_t;

    int n_tests = 0, n_fail = 0;
    int n_req = 0, n_stall = 0, n_berr = 0;
    logic chk_en = 0;
    logic exp_stall = 0, exp_req = 0, exp_we_o = 0, exp_we_wb = 0, exp_berr = 0, exp_mis = 0;
    logic [31:0] exp_addr = 0, exp_wdo = 0, exp_wdata = 0;
    logic [3:0]  exp_be = 0;
    logic [4:0]  exp_waddr = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall", 32'(stall_wb_o), 32'(exp_stall));
            cmp("req", 32'(data_req_o), 32'(exp_req));
            cmp("we_wb", 32'(regfile_we_wb_o), 32'(exp_we_wb));
            cmp("bus_err", 32'(bus_err_o), 32'(exp_berr));
            cmp("misalign_err", 32'(misalign_err_o), 32'(exp_mis));
            if (exp_req) begin
                cmp("addr_o", data_addr_o, exp_addr);
                cmp("we_o", 32'(data_we_o), 32'(exp_we_o));
                cmp("be_o", 32'(data_be_o), 32'(exp_be));
                if (exp_we_o) cmp("wdata_o", data_wdata_o, exp_wdo);
            end
            if (exp_we_wb) begin
                cmp("waddr_wb", 32'(regfile_waddr_wb_o), 32'(exp_waddr));
                cmp("wdata_wb", regfile_wdata_wb_o, exp_wdata);
            end
            if (data_req_o) n_req++;
            if (stall_wb_o) n_stall++;
            if (bus_err_o) n_berr++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic logic m_legal(input logic [2:0] be);
        return be inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic logic m_mis(input op_t op);
`ifdef WB_MISALIGN_CHK_EN
        return (op.be[1:0] == 2'b01 && (op.alu % 2) != 0) || (op.be == 3'b010 && (op.alu % 4) != 0);
`else
        return (op.be == 3'b111) && (op.be != 3'b111);
`endif
    endfunction

    function automatic int unsigned m_idx(input op_t op);
        int unsigned a;
        a = op.alu % 4;
        if (op.be[1:0] == 2'b01) return a - (a % 2);
        if (op.be[1:0] == 2'b10) return 0;
        return a;
    endfunction

    function automatic logic [31:0] m_load(input op_t op, input logic [31:0] rdata);
        logic [31:0] v, full;
        if (op.be[1:0] == 2'b10) return rdata;
        full = (op.be[1:0] == 2'b00) ? 32'd256 : 32'd65536;
        v = (rdata >> (8 * m_idx(op))) % full;
        if (!op.be[2] && v >= full / 2) v = v - full;
        return v;
    endfunction

    function automatic logic [31:0] m_wb(input op_t op, input logic [31:0] rdata);
        if (op.mux == M_MEM) return m_load(op, rdata);
        if (op.mux == M_PC) return op.pc + PC_INCR;
        return op.alu;
    endfunction

    function automatic logic [3:0] m_be(input op_t op);
        if (op.be[1:0] == 2'b00) return 4'(32'd1 << m_idx(op));
        if (op.be[1:0] == 2'b01) return 4'(32'd3 << m_idx(op));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input op_t op);
        if (op.be[1:0] == 2'b00) return (op.rs2 % 256) * 32'h01010101;
        if (op.be[1:0] == 2'b01) return (op.rs2 % 65536) * 32'h00010001;
        return op.rs2;
    endfunction

    function automatic op_t mk(input logic [31:0] pc, alu, rs2, input logic [4:0] rd, input logic we,
                               input logic [1:0] mux, input logic mreq, mwe, input logic [2:0] be);
        op_t o;
        o = '{pc: pc, alu: alu, rs2: rs2, rd: rd, we: we, mux: mux, mreq: mreq, mwe: mwe, be: be};
        return o;
    endfunction

    function automatic op_t mk_ld(input logic [2:0] be, input logic [31:0] a, input logic [4:0] rd);
        return mk(32'h0, a, 32'h5A5A5A5A, rd, 1'b1, M_MEM, 1'b1, 1'b0, be);
    endfunction

    function automatic op_t mk_st(input logic [2:0] be, input logic [31:0] a, input logic [31:0] d);
        return mk(32'h0, a, d, 5'd0, 1'b0, M_ALU, 1'b1, 1'b1, be);
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        exp_stall = 0; exp_req = 0; exp_we_wb = 0; exp_berr = 0; exp_mis = 0;
    endtask

    task automatic drive(input op_t op);
        valid_i = 1; pc_i = op.pc; alu_result_i = op.alu; rs2_rdata_i = op.rs2;
        regfile_waddr_i = op.rd; regfile_we_i = op.we; regfile_wr_mux_i = op.mux;
        mem_req_i = op.mreq; mem_we_i = op.mwe; mem_be_i = op.be;
    endtask

    task automatic set_mem_exp(input op_t op);
        exp_addr = op.alu - (op.alu % 4);
        exp_we_o = op.mwe;
        exp_be   = m_be(op);
        exp_wdo  = m_wd(op);
    endtask

    // One op issued behind a bubble; gdly = REQ cycles before gnt, rdly = RESP cycles before rvalid.
    task automatic run_op(input op_t op, input int gdly, input int rdly, input logic [31:0] rdata,
                          input logic rv_early, input logic lit_en, input logic [31:0] lit_wd,
                          input logic [3:0] lit_be, input logic [31:0] lit_addr);
        int t, r;
        logic fin, in_resp;
        drive(op);
        quiet();
        step();
        valid_i = 0;
        if (!op.mreq) begin
            exp_we_wb = op.we && (op.rd != 0);
            exp_waddr = op.rd;
            exp_wdata = m_wb(op, rdata);
            if (lit_en) begin
                @(negedge clk);
                cmp("lit_wdata_wb", regfile_wdata_wb_o, lit_wd);
            end
            step();
        end else if (!m_legal(op.be) || m_mis(op)) begin
            exp_mis = m_legal(op.be) && m_mis(op);
            step();
        end else begin
            set_mem_exp(op);
            t = 0; r = 0; fin = 0; in_resp = 0;
            data_rdata_i = rdata;
            while (!fin) begin
                exp_berr = 0; exp_we_wb = 0;
                exp_req = !in_resp;
                exp_stall = 1;
                data_gnt_i = !in_resp && (t == gdly);
                data_rvalid_i = in_resp ? (r == rdly) : rv_early;
                if (!in_resp && t == gdly && op.mwe) begin
                    exp_stall = 0; fin = 1;
                end else if (in_resp && r == rdly) begin
                    exp_stall = 0; fin = 1;
                    exp_we_wb = op.we && (op.rd != 0);
                    exp_waddr = op.rd;
                    exp_wdata = m_wb(op, rdata);
                end else if (t == TIMEOUT - 1) begin
                    exp_stall = 0; exp_berr = 1; fin = 1;
                end
                if (lit_en && (t == 0 || fin)) begin
                    @(negedge clk);
                    if (t == 0) begin
                        cmp("lit_addr_o", data_addr_o, lit_addr);
                        cmp("lit_be_o", 32'(data_be_o), 32'(lit_be));
                    end
                    if (fin && op.mwe) cmp("lit_wdata_o", data_wdata_o, lit_wd);
                    if (fin && !op.mwe) cmp("lit_wdata_wb", regfile_wdata_wb_o, lit_wd);
                end
                if (!in_resp && data_gnt_i) in_resp = 1;
                else if (in_resp) r++;
                t++;
                step();
            end
            data_gnt_i = 0;
            data_rvalid_i = 0;
        end
        quiet();
    endtask

    int s_req, s_stall, s_berr;
    op_t op;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_stall", 32'(stall_wb_o), 32'd0);
        cmp("rst_req", 32'(data_req_o), 32'd0);
        cmp("rst_addr", data_addr_o, 32'd0);
        cmp("rst_we_o", 32'(data_we_o), 32'd0);
        cmp("rst_be_o", 32'(data_be_o), 32'd0);
        cmp("rst_wdata_o", data_wdata_o, 32'd0);
        cmp("rst_waddr_wb", 32'(regfile_waddr_wb_o), 32'd0);
        cmp("rst_we_wb", 32'(regfile_we_wb_o), 32'd0);
        cmp("rst_wdata_wb", regfile_wdata_wb_o, 32'd0);
        cmp("rst_bus_err", 32'(bus_err_o), 32'd0);
        cmp("rst_misalign", 32'(misalign_err_o), 32'd0);
        step();
        rst = 0;
        quiet();
        chk_en = 1;
        step();

        // ALU / PC+4 / rd=x0 / pc wrap
        run_op(mk(32'h0, 32'h12345678, 32'h0, 5'd5, 1, M_ALU, 0, 0, 3'b010), 0, 0, 0, 0, 1, 32'h12345678, 0, 0);
        run_op(mk(32'h40, 32'h0, 32'h0, 5'd1, 1, M_PC, 0, 0, 3'b010), 0, 0, 0, 0, 1, 32'h44, 0, 0);
        run_op(mk(32'h40, 32'hFFFF0000, 32'h0, 5'd0, 1, M_ALU, 0, 0, 3'b010), 0, 0, 0, 0, 0, 0, 0, 0);
        run_op(mk(32'hFFFFFFFE, 32'h0, 32'h0, 5'd9, 1, M_PC, 0, 0, 3'b010), 0, 0, 0, 0, 1, 32'h2, 0, 0);

        // LB 0x103, gnt 2 cycles late, rvalid one cycle after earliest; rvalid noise during REQ ignored
        s_req = n_req; s_stall = n_stall;
        run_op(mk_ld(3'b000, 32'h103, 5'd3), 2, 1, 32'h80000000, 1, 1, 32'hFFFFFF80, 4'b1000, 32'h100);
        cmp("lb_req_cycles", 32'(n_req - s_req), 32'd3);
        cmp("lb_stall_cycles", 32'(n_stall - s_stall), 32'd4);

        run_op(mk_ld(3'b101, 32'h102, 5'd4), 0, 0, 32'hBEEF0000, 0, 1, 32'h0000BEEF, 4'b1100, 32'h100);
        run_op(mk_ld(3'b001, 32'h102, 5'd4), 1, 0, 32'hBEEF0000, 0, 1, 32'hFFFFBEEF, 4'b1100, 32'h100);
        run_op(mk_ld(3'b100, 32'h200, 5'd6), 0, 0, 32'h000000F0, 0, 1, 32'h000000F0, 4'b0001, 32'h200);
        run_op(mk_ld(3'b010, 32'h204, 5'd7), 0, 2, 32'hCAFEBABE, 0, 1, 32'hCAFEBABE, 4'b1111, 32'h204);

        // stores
        s_stall = n_stall;
        run_op(mk_st(3'b000, 32'h101, 32'h000000AB), 1, 0, 0, 0, 1, 32'hABABABAB, 4'b0010, 32'h100);
        cmp("sb_stall_cycles", 32'(n_stall - s_stall), 32'd1);
        run_op(mk_st(3'b001, 32'h302, 32'h1234CAFE), 0, 0, 0, 1, 1, 32'hCAFECAFE, 4'b1100, 32'h300);
        run_op(mk_st(3'b010, 32'h400, 32'h01020304), 3, 0, 0, 0, 1, 32'h01020304, 4'b1111, 32'h400);

        // illegal size code: no request, no write, no stall
        run_op(mk(32'h0, 32'h100, 32'h0, 5'd7, 1, M_MEM, 1, 0, 3'b011), 0, 0, 32'h11111111, 0, 0, 0, 0, 0);

        // LW with gnt never: bus error after TIMEOUT cycles
        s_req = n_req; s_stall = n_stall; s_berr = n_berr;
        run_op(mk_ld(3'b010, 32'h500, 5'd8), 1000, 0, 32'h77777777, 0, 0, 0, 0, 0);
        cmp("to_req_cycles", 32'(n_req - s_req), 32'(TIMEOUT));
        cmp("to_stall_cycles", 32'(n_stall - s_stall), 32'(TIMEOUT - 1));
        cmp("to_bus_err_pulses", 32'(n_berr - s_berr), 32'd1);

        // reset while in RESP: request gone, pending write lost
        op = mk_ld(3'b010, 32'h600, 5'd10);
        drive(op);
        quiet();
        step();
        valid_i = 0;
        set_mem_exp(op);
        exp_req = 1; exp_stall = 1; data_gnt_i = 1;
        step();
        data_gnt_i = 0;
        exp_req = 0; exp_stall = 1;
        step();
        rst = 1;
        exp_stall = 0;
        @(negedge clk);
        cmp("rst_mid_req", 32'(data_req_o), 32'd0);
        cmp("rst_mid_stall", 32'(stall_wb_o), 32'd0);
        step();
        rst = 0;
        data_rvalid_i = 1; data_rdata_i = 32'h99999999;
        step();
        data_rvalid_i = 0;

        // LW 0x102
        op = mk_ld(3'b010, 32'h102, 5'd11);
`ifdef WB_MISALIGN_CHK_EN
        run_op(op, 0, 0, 32'h11223344, 0, 0, 0, 0, 0);
`else
        run_op(op, 0, 0, 32'h11223344, 0, 1, 32'h11223344, 4'b1111, 32'h100);
`endif
        // misaligned halfword
        run_op(mk_ld(3'b001, 32'h703, 5'd12), 0, 0, 32'hA1B2C3D4, 0, 0, 0, 0, 0);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
